// File: rtl/fxp_to_flp_scheduler.sv
// fxp_to_flp_scheduler
// Shares one fixed-to-float converter among C_NUM_CH fixed-point requesters.
// A round-robin arbiter picks a requester, holds its operand on the converter
// input, pulses the trigger, then returns the converter result (or a timeout
// abort) tagged with the originating channel.
//
// Ports:
//   CLK, nRST     clock, synchronous active-low reset
//   REQ           per-channel request level (sampled only in IDLE)
//   REQ_DATA      packed operands, channel i at [i*C_FXP_WIDTH +: C_FXP_WIDTH]
//   ACK           one-hot, one-cycle pulse: operand of that channel captured
//   CONV_FXP      registered operand to the converter
//   CONV_TRIGGER  one-cycle converter start pulse
//   CONV_FLP      converter result
//   CONV_VALID    converter result-valid pulse (honoured only in WAIT)
//   RES_VALID     one-cycle result pulse
//   RES_CH        channel of the result
//   RES_DATA      float result, 0 on timeout
//   RES_ZERO      captured operand was exactly zero
//   RES_ERR       result aborted by timeout (qualified by RES_VALID)
//   BUSY          scheduler not idle
//   ERR_TIMEOUT   sticky timeout flag, cleared only by reset
module fxp_to_flp_scheduler #(
   parameter int unsigned C_NUM_CH       = 3,
   parameter int unsigned C_FXP_WIDTH    = 16,
   parameter int unsigned C_FLP_WIDTH    = 32,
   parameter int unsigned C_CONV_TIMEOUT = 15,
   parameter int unsigned C_CH_W         = $clog2(C_NUM_CH)
) (
   input  logic                              CLK,
   input  logic                              nRST,
   input  logic [C_NUM_CH-1:0]               REQ,
   input  logic [C_NUM_CH*C_FXP_WIDTH-1:0]   REQ_DATA,
   output logic [C_NUM_CH-1:0]               ACK,
   output logic [C_FXP_WIDTH-1:0]            CONV_FXP,
   output logic                              CONV_TRIGGER,
   input  logic [C_FLP_WIDTH-1:0]            CONV_FLP,
   input  logic                              CONV_VALID,
   output logic                              RES_VALID,
   output logic [C_CH_W-1:0]                 RES_CH,
   output logic [C_FLP_WIDTH-1:0]            RES_DATA,
   output logic                              RES_ZERO,
   output logic                              RES_ERR,
   output logic                              BUSY,
   output logic                              ERR_TIMEOUT
);

   localparam int unsigned CNT_W = $clog2(C_CONV_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]             state_q,       state_d;
   logic [C_CH_W-1:0]      last_grant_q,  last_grant_d;
   logic [CNT_W-1:0]       cnt_q,         cnt_d;
   logic [C_NUM_CH-1:0]    ack_q,         ack_d;
   logic [C_FXP_WIDTH-1:0] conv_fxp_q,    conv_fxp_d;
   logic                   trig_q,        trig_d;
   logic                   res_valid_q,   res_valid_d;
   logic [C_CH_W-1:0]      res_ch_q,      res_ch_d;
   logic [C_FLP_WIDTH-1:0] res_data_q,    res_data_d;
   logic                   res_zero_q,    res_zero_d;
   logic                   res_err_q,     res_err_d;
   logic                   busy_q,        busy_d;
   logic                   err_to_q,      err_to_d;

   logic [C_FXP_WIDTH-1:0] req_op [C_NUM_CH];
   logic                   gnt_found;
   logic [C_CH_W-1:0]      gnt_ch;
   logic [C_CH_W-1:0]      cand_ch;

   // Unpack the flat operand bus into one entry per channel.
   always_comb begin
      for (int unsigned i = 0; i < C_NUM_CH; i++) begin
         req_op[i] = REQ_DATA[i*C_FXP_WIDTH +: C_FXP_WIDTH];
      end
   end

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      gnt_found = 1'b0;
      gnt_ch    = '0;
      cand_ch   = '0;
      for (int unsigned i = 1; i <= C_NUM_CH; i++) begin
         cand_ch = C_CH_W'((32'(last_grant_q) + i) % C_NUM_CH);
         if (!gnt_found && REQ[cand_ch]) begin
            gnt_found = 1'b1;
            gnt_ch    = cand_ch;
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      ack_d        = '0;
      conv_fxp_d   = conv_fxp_q;
      trig_d       = 1'b0;
      res_valid_d  = 1'b0;
      res_ch_d     = res_ch_q;
      res_data_d   = res_data_q;
      res_zero_d   = res_zero_q;
      res_err_d    = res_err_q;
      err_to_d     = err_to_q;

      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               conv_fxp_d   = req_op[gnt_ch];
               ack_d        = C_NUM_CH'(1) << gnt_ch;
               res_ch_d     = gnt_ch;
               res_zero_d   = (req_op[gnt_ch] == '0);
               last_grant_d = gnt_ch;
               trig_d       = 1'b1;
               state_d      = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (CONV_VALID) begin
               res_data_d  = CONV_FLP;
               res_err_d   = 1'b0;
               res_valid_d = 1'b1;
               state_d     = S_DONE;
            end else if (cnt_q == CNT_W'(C_CONV_TIMEOUT)) begin
               res_data_d  = '0;
               res_err_d   = 1'b1;
               err_to_d    = 1'b1;
               res_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               cnt_d = CNT_W'(cnt_q + 1'b1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; last_grant resets so channel 0 wins first.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q      <= S_IDLE;
         last_grant_q <= C_CH_W'(C_NUM_CH - 1);
         cnt_q        <= '0;
         ack_q        <= '0;
         conv_fxp_q   <= '0;
         trig_q       <= 1'b0;
         res_valid_q  <= 1'b0;
         res_ch_q     <= '0;
         res_data_q   <= '0;
         res_zero_q   <= 1'b0;
         res_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         err_to_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         ack_q        <= ack_d;
         conv_fxp_q   <= conv_fxp_d;
         trig_q       <= trig_d;
         res_valid_q  <= res_valid_d;
         res_ch_q     <= res_ch_d;
         res_data_q   <= res_data_d;
         res_zero_q   <= res_zero_d;
         res_err_q    <= res_err_d;
         busy_q       <= busy_d;
         err_to_q     <= err_to_d;
      end
   end

   assign ACK          = ack_q;
   assign CONV_FXP     = conv_fxp_q;
   assign CONV_TRIGGER = trig_q;
   assign RES_VALID    = res_valid_q;
   assign RES_CH       = res_ch_q;
   assign RES_DATA     = res_data_q;
   assign RES_ZERO     = res_zero_q;
   assign RES_ERR      = res_err_q;
   assign BUSY         = busy_q;
   assign ERR_TIMEOUT  = err_to_q;

endmodule

// File: tb/tb_fxp_to_flp_scheduler.sv
// Testbench for fxp_to_flp_scheduler: converter model, scoreboard of expected
// results filled at grant time and drained at RES_VALID.
module tb_fxp_to_flp_scheduler;

   localparam int unsigned NCH = 3;
   localparam int unsigned FXW = 16;
   localparam int unsigned FLW = 32;
   localparam int unsigned TO  = 15;
   localparam int unsigned CHW = 2;

   logic               CLK = 1'b0;
   logic               nRST;
   logic [NCH-1:0]     REQ;
   logic [NCH*FXW-1:0] REQ_DATA;
   logic [NCH-1:0]     ACK;
   logic [FXW-1:0]     CONV_FXP;
   logic               CONV_TRIGGER;
   logic [FLW-1:0]     CONV_FLP;
   logic               CONV_VALID;
   logic               RES_VALID;
   logic [CHW-1:0]     RES_CH;
   logic [FLW-1:0]     RES_DATA;
   logic               RES_ZERO;
   logic               RES_ERR;
   logic               BUSY;
   logic               ERR_TIMEOUT;

   fxp_to_flp_scheduler #(
      .C_NUM_CH(NCH), .C_FXP_WIDTH(FXW), .C_FLP_WIDTH(FLW), .C_CONV_TIMEOUT(TO)
   ) dut (
      .CLK(CLK), .nRST(nRST), .REQ(REQ), .REQ_DATA(REQ_DATA), .ACK(ACK),
      .CONV_FXP(CONV_FXP), .CONV_TRIGGER(CONV_TRIGGER), .CONV_FLP(CONV_FLP),
      .CONV_VALID(CONV_VALID), .RES_VALID(RES_VALID), .RES_CH(RES_CH),
      .RES_DATA(RES_DATA), .RES_ZERO(RES_ZERO), .RES_ERR(RES_ERR),
      .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT)
   );

   always #5 CLK = ~CLK;

   // Converter model: one-cycle latency, result = {A5A5, operand}.
   logic        conv_en;
   logic        late_vld;
   logic        cv_q;
   logic [31:0] cf_q;
   always @(posedge CLK) begin
      cv_q <= conv_en & CONV_TRIGGER;
      cf_q <= {16'hA5A5, CONV_FXP};
   end
   assign CONV_VALID = cv_q | late_vld;
   assign CONV_FLP   = cf_q;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
      end
   endtask

   typedef struct {
      logic [CHW-1:0] ch;
      logic [31:0]    data;
      logic           zero;
      logic           err;
      int             gcyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   logic [2:0]  req_s = '0;
   logic [15:0] op_s [NCH];
   int          last_m = NCH - 1;
   logic [15:0] held = '0;
   int          n_res = 0;
   int          res_cyc[$];
   int          res_chl[$];

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: reference arbiter, operand-hold and scoreboard checks.
   always @(negedge CLK) begin
      int    g;
      int    c;
      logic [2:0] onehot;
      exp_t  e;
      if (!nRST) begin
         sb.delete();
         last_m = NCH - 1;
      end else begin
         check_eq("trig_with_ack", 64'(CONV_TRIGGER), 64'(|ACK));
         if (ACK != '0) begin
            g = -1;
            for (int k = 1; k <= int'(NCH); k++) begin
               c = (last_m + k) % int'(NCH);
               if (g < 0 && req_s[c]) g = c;
            end
            if (g < 0) begin
               check_eq("ack_unrequested", 64'(ACK), 64'(0));
            end else begin
               onehot = 3'b001 << g;
               check_eq("ack_onehot", 64'(ACK), 64'(onehot));
               check_eq("conv_fxp", 64'(CONV_FXP), 64'(op_s[g]));
               e.ch   = CHW'(g);
               e.zero = (op_s[g] == 16'h0000);
               e.err  = !conv_en;
               e.data = conv_en ? {16'hA5A5, op_s[g]} : 32'h0;
               e.gcyc = cyc;
               sb.push_back(e);
               last_m = g;
               held   = op_s[g];
            end
         end else if (BUSY) begin
            check_eq("fxp_hold", 64'(CONV_FXP), 64'(held));
         end
         if (RES_VALID) begin
            if (sb.size() == 0) begin
               check_eq("spurious_res", 64'(RES_VALID), 64'(0));
            end else begin
               e = sb.pop_front();
               check_eq("res_ch",   64'(RES_CH),   64'(e.ch));
               check_eq("res_data", 64'(RES_DATA), 64'(e.data));
               check_eq("res_zero", 64'(RES_ZERO), 64'(e.zero));
               check_eq("res_err",  64'(RES_ERR),  64'(e.err));
               check_eq("latency",  64'(cyc - e.gcyc), e.err ? 64'(TO + 2) : 64'(2));
            end
            n_res++;
            res_cyc.push_back(cyc);
            res_chl.push_back(int'(RES_CH));
         end
      end
      req_s = REQ;
      for (int i = 0; i < int'(NCH); i++) op_s[i] = REQ_DATA[i*FXW +: FXW];
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic set_op(input int ch, input logic [15:0] v);
      REQ_DATA[ch*FXW +: FXW] = v;
   endtask

   // Serve requests (dropping REQ on ACK) until everything has drained.
   task automatic serve(input string tag, input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick(1);
         REQ = REQ & ~ACK;
         if (REQ == '0 && !BUSY && sb.size() == 0) done = 1'b1;
      end
      check_eq(tag, 64'(done), 64'(1));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ack"},  64'(ACK), 64'(0));
      check_eq({tag, "_fxp"},  64'(CONV_FXP), 64'(0));
      check_eq({tag, "_trig"}, 64'(CONV_TRIGGER), 64'(0));
      check_eq({tag, "_rv"},   64'(RES_VALID), 64'(0));
      check_eq({tag, "_rch"},  64'(RES_CH), 64'(0));
      check_eq({tag, "_rd"},   64'(RES_DATA), 64'(0));
      check_eq({tag, "_rz"},   64'(RES_ZERO), 64'(0));
      check_eq({tag, "_re"},   64'(RES_ERR), 64'(0));
      check_eq({tag, "_busy"}, 64'(BUSY), 64'(0));
      check_eq({tag, "_eto"},  64'(ERR_TIMEOUT), 64'(0));
   endtask

   initial begin
      int base;
      int nack;
      logic got;
      nRST = 1'b0; REQ = '0; REQ_DATA = '0; conv_en = 1'b1; late_vld = 1'b0;
      tick(3);
      check_all_zero("rst");
      nRST = 1'b1;
      tick(2);

      // Single request on channel 1.
      base = n_res;
      set_op(1, 16'h1000);
      REQ = 3'b010;
      serve("single_done", 30);
      check_eq("single_count", 64'(n_res - base), 64'(1));

      // Zero operand on ch2, plus a two-channel request resolved round-robin.
      set_op(2, 16'h0000);
      REQ = 3'b100;
      serve("zero_done", 30);
      set_op(0, 16'h7FFF);
      set_op(2, 16'h8001);
      REQ = 3'b101;
      serve("pair_done", 40);

      // Fairness with all channels held high after reset.
      nRST = 1'b0; tick(2); nRST = 1'b1; tick(1);
      set_op(0, 16'h0011); set_op(1, 16'h0022); set_op(2, 16'h0033);
      base = res_chl.size();
      REQ  = 3'b111;
      nack = 0;
      for (int i = 0; i < 60 && nack < 6; i++) begin
         tick(1);
         if (ACK != '0) nack++;
      end
      REQ = '0;
      serve("rr_done", 30);
      check_eq("rr_count", 64'(res_chl.size() - base), 64'(6));
      if (res_chl.size() - base == 6) begin
         for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("rr_ch%0d", i), 64'(res_chl[base + i]), 64'(i % 3));
            if (i > 0) check_eq($sformatf("rr_gap%0d", i),
                                64'(res_cyc[base + i] - res_cyc[base + i - 1]), 64'(4));
         end
      end

      // Operand churn during a conversion.
      set_op(0, 16'h1234);
      REQ = 3'b001;
      got = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (ACK != '0) got = 1'b1;
         REQ = REQ & ~ACK;
         if (got) REQ_DATA = 48'($urandom) ^ {16'($urandom), 32'h0};
      end
      serve("stab_done", 20);

      // Timeout, late CONV_VALID, sticky flag.
      conv_en = 1'b0;
      REQ = 3'b001;
      set_op(0, 16'h0042);
      serve("to_done", 40);
      check_eq("eto_set", 64'(ERR_TIMEOUT), 64'(1));
      base = n_res;
      late_vld = 1'b1; tick(1); late_vld = 1'b0;
      tick(5);
      check_eq("late_vld_nores", 64'(n_res - base), 64'(0));
      conv_en = 1'b1;
      set_op(1, 16'h0BEE);
      REQ = 3'b010;
      serve("after_to_done", 30);
      check_eq("eto_sticky", 64'(ERR_TIMEOUT), 64'(1));

      // Reset in the middle of WAIT.
      conv_en = 1'b0;
      set_op(2, 16'h5555);
      REQ = 3'b100;
      tick(1);
      REQ = REQ & ~ACK;
      tick(4);
      base = n_res;
      nRST = 1'b0;
      tick(2);
      check_all_zero("midrst");
      conv_en = 1'b1;
      nRST = 1'b1;
      REQ = 3'b111;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(1);
         if (ACK != '0) begin
            got = 1'b1;
            check_eq("midrst_first_grant", 64'(ACK), 64'(3'b001));
            REQ = REQ & ~ACK;
         end
      end
      check_eq("midrst_granted", 64'(got), 64'(1));
      serve("midrst_done", 60);
      check_eq("midrst_res_count", 64'(n_res - base), 64'(3));
      check_eq("sb_empty", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
